pulse_stretch: RTL
==================

Name: pulse_stretch

Overview:
- Output-side counterpart to the input debouncer: converts single-cycle internal event strobes into clean, human/board-visible output pulses (LED, relay, buzzer, external pin).
- Each event produces one active pulse of exactly HIGH_TIME cycles, followed by at least GAP_TIME idle cycles.
- Events arriving while busy are queued in a saturating pending counter.
- Sits between core logic and an output pad, clocked by the same system clock as the debouncers.

Parameters:
- INIT_VALUE, 1'b0: idle (inactive) level of data_o; the active level is ~INIT_VALUE.
- HIGH_TIME, 16'd10000: active pulse length in clk cycles; legal range 1..65535.
- GAP_TIME, 16'd10000: minimum inactive cycles between consecutive pulses; legal range 1..65535.
- PEND_W, 4: width of the pending-event counter; queue depth is 2^PEND_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- pulse_i  input  1  event strobe; each cycle sampled high counts as one event.
- data_o  output  1  stretched output pulse, registered.
- busy_o  output  1  high while a pulse or gap is in progress, registered.
- pend_o  output  PEND_W  number of queued events not yet started.
- overflow_o  output  1  one-cycle flag: an event was dropped because the queue was full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_o=INIT_VALUE, busy_o=0, pend_o=0, overflow_o=0.
  - State=IDLE, duration counter cleared.
  - Takes effect immediately, including mid-pulse; queued events are discarded.
- FSM states: IDLE, ACTIVE, GAP. One 16-bit down-counter is shared by ACTIVE and GAP.
- IDLE:
  - On pulse_i=1, go to ACTIVE and load the counter with HIGH_TIME-1.
  - data_o=~INIT_VALUE and busy_o=1 from the next cycle, so latency is 1 cycle.
  - pend_o is unchanged.
- ACTIVE:
  - data_o=~INIT_VALUE, decrement each cycle.
  - When the counter is 0, go to GAP and load GAP_TIME-1.
  - data_o is active for exactly HIGH_TIME cycles.
- GAP:
  - data_o=INIT_VALUE, busy_o=1, decrement each cycle.
  - When the counter is 0:
    - If pend_o>0: go to ACTIVE (load HIGH_TIME-1) and decrement pend_o. The next pulse begins the following cycle.
    - Else: go to IDLE. busy_o=0 from the following cycle.
- Events while in ACTIVE or GAP: pend_o increments by 1.
- Saturation:
  - If pend_o=2^PEND_W-1 and pulse_i=1 in ACTIVE/GAP, the event is dropped, pend_o holds, and overflow_o=1 on the next cycle only.
  - Consecutive dropped events give consecutive overflow_o cycles.
- Simultaneous events:
  - GAP end with pend_o>0 and pulse_i=1: pend_o is unchanged (dequeue and enqueue cancel).
  - GAP end with pend_o at maximum and pulse_i=1: no overflow, pend_o unchanged.
  - GAP end with pend_o=0 and pulse_i=1: the event is queued (pend_o=1) and the FSM goes to IDLE. The queued pulse starts on the next cycle via an IDLE check: pend_o>0 acts like pulse_i and decrements pend_o.
- Period between pulse starts is never less than HIGH_TIME+GAP_TIME cycles.
- data_o has no glitches: it is driven directly from a flop and toggles only on state transitions.
- Out-of-range parameters (0) are illegal; simulation asserts at elaboration.

Test Plan:
All cases use HIGH_TIME=4, GAP_TIME=3, PEND_W=2, INIT_VALUE=0 unless stated.
1. Reset: hold rst_n=0 with pulse_i toggling -> data_o=0, busy_o=0, pend_o=0, overflow_o=0 throughout; no pulse after release.
2. Single event: pulse_i=1 at cycle 10 -> data_o=1 on cycles 11-14, 0 from 15; busy_o=1 on 11-17, 0 from 18.
3. Queued events: pulse_i at 10, 12, 13 ->
   - pend_o: 1 at 13, 2 at 14.
   - data_o high on 11-14, 18-21, 25-28.
   - pend_o returns to 0 at 25; busy_o drops at 32.
4. Overflow: pulse_i held high cycles 10-15 ->
   - pend_o reaches 3 at cycle 14.
   - overflow_o=1 on cycles 15-16.
   - Exactly 4 output pulses, starting at 11, 18, 25, 32.
5. Reset mid-operation: assert rst_n=0 at cycle 12 of test 3 -> data_o=0 and pend_o=0 immediately; no pulses after release.
6. Polarity: INIT_VALUE=1 with a single event at cycle 10 -> data_o idles 1, is 0 on cycles 11-14, returns to 1 at 15.

Source files
------------

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: event strobe in, stretched pulse and status out.
//   pulse_i    : single-cycle event strobe (driven by the core logic)
//   data_o     : stretched output pulse toward the pad
//   busy_o     : pulse or trailing gap in progress
//   pend_o     : queued events not yet started
//   overflow_o : one-cycle flag, an event was dropped because the queue was full
interface pulse_stretch_if #(
   parameter int PEND_W = 4
);
   logic              pulse_i;
   logic              data_o;
   logic              busy_o;
   logic [PEND_W-1:0] pend_o;
   logic              overflow_o;

   modport master (
      output pulse_i,
      input  data_o, busy_o, pend_o, overflow_o
   );

   modport slave (
      input  pulse_i,
      output data_o, busy_o, pend_o, overflow_o
   );
endinterface

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event strobes into output pulses of
// exactly HIGH_TIME cycles, each followed by at least GAP_TIME idle cycles.
// Events arriving while busy are queued in a saturating pending counter.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : pulse_stretch_if slave (pulse_i in; data_o, busy_o, pend_o,
//           overflow_o out, all registered)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | output inactive, waiting for pulse_i or a queued event
// ST_ACTIVE | output at ~INIT_VALUE, counting down HIGH_TIME cycles
// ST_GAP    | output at INIT_VALUE, counting down GAP_TIME cycles
module pulse_stretch #(
   parameter logic        INIT_VALUE = 1'b0,
   parameter logic [15:0] HIGH_TIME  = 16'd10000,
   parameter logic [15:0] GAP_TIME   = 16'd10000,
   parameter int          PEND_W     = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   pulse_stretch_if.slave  bus
);

   if (HIGH_TIME == 16'd0) begin : g_bad_high_time
      $error("pulse_stretch: HIGH_TIME must be in 1..65535");
   end
   if (GAP_TIME == 16'd0) begin : g_bad_gap_time
      $error("pulse_stretch: GAP_TIME must be in 1..65535");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              data_q, data_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic              enq;
   logic              deq;
   logic              pend_nz;
   logic              cnt_zero;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      ovf_d    = 1'b0;
      enq      = 1'b0;
      deq      = 1'b0;
      pend_nz  = (pend_q != '0);
      cnt_zero = (cnt_q == 16'd0);

      case (state_q)
         ST_IDLE: begin
            // A queued event left over from a gap-end collision starts
            // exactly like a fresh strobe; a strobe in the same cycle
            // then takes its place in the queue.
            if (bus.pulse_i || pend_nz) begin
               state_d = ST_ACTIVE;
               cnt_d   = HIGH_TIME - 16'd1;
            end
            deq = pend_nz;
            enq = bus.pulse_i && pend_nz;
         end
         ST_ACTIVE: begin
            enq = bus.pulse_i;
            if (cnt_zero) begin
               state_d = ST_GAP;
               cnt_d   = GAP_TIME - 16'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_GAP: begin
            enq = bus.pulse_i;
            if (cnt_zero) begin
               if (pend_nz) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = HIGH_TIME - 16'd1;
                  deq     = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase

      // Dequeue and enqueue in the same cycle cancel, so a full queue
      // never overflows at the moment a slot is being freed.
      if (enq && !deq) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_W'(1);
         end
      end else if (deq && !enq) begin
         pend_d = pend_q - PEND_W'(1);
      end

      data_d = (state_d == ST_ACTIVE) ? ~INIT_VALUE : INIT_VALUE;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         pend_q  <= '0;
         data_q  <= INIT_VALUE;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.data_o     = data_q;
   assign bus.busy_o     = busy_q;
   assign bus.pend_o     = pend_q;
   assign bus.overflow_o = ovf_q;

endmodule
